// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared width defaults and queue-entry type for the instruction fetch path.
// Used by imem_fetch_ctrl and its fetch queue. The IMem uses the same constants.
package imem_fetch_ctrl_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int IMEM_AW_DEF    = 6;
   localparam int FQ_DEPTH_DEF   = 4;

   typedef struct packed {
      logic [31:0]               pc;
      logic [DATA_WIDTH_DEF-1:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// Circular fetch queue: 0/1/2 pushes and 1 pop per cycle, synchronous flush,
// registered head entry that holds its last value while the queue is empty.
module imem_fetch_ctrl_fetch_queue
   import imem_fetch_ctrl_pkg::*;
#(
   parameter  int DEPTH = FQ_DEPTH_DEF,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic [1:0]    push_cnt_i,
   input  fq_entry_t     push0_i,
   input  fq_entry_t     push1_i,
   input  logic          pop_i,
   output fq_entry_t     head_o,
   output logic [CW-1:0] count_o,
   output logic [CW-1:0] free_o
);

   fq_entry_t       mem_q [DEPTH];
   fq_entry_t       head_ent_q, head_ent_d;
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d, tail1;
   logic [CW-1:0]   count_q, count_d;
   logic            wr0, wr1;

   always_comb begin
      tail1      = tail_q + PW'(1);
      wr0        = !flush_i && (push_cnt_i != 2'd0);
      wr1        = !flush_i && (push_cnt_i == 2'd2);
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      head_ent_d = head_ent_q;
      if (flush_i) begin
         head_d  = tail_q;
         count_d = '0;
      end else begin
         if (pop_i) head_d = head_q + PW'(1);
         tail_d  = tail_q + PW'(push_cnt_i);
         count_d = count_q + CW'(push_cnt_i) - CW'(pop_i);
         // Look ahead at the post-edge head slot, forwarding same-cycle writes.
         if (count_d != '0) begin
            if (wr1 && (head_d == tail1))
               head_ent_d = push1_i;
            else if (wr0 && (head_d == tail_q))
               head_ent_d = push0_i;
            else
               head_ent_d = mem_q[head_d];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         head_ent_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         head_ent_q <= head_ent_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr0) mem_q[tail_q] <= push0_i;
      if (wr1) mem_q[tail1]  <= push1_i;
   end

   assign head_o  = head_ent_q;
   assign count_o = count_q;
   assign free_o  = CW'(DEPTH) - count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, drives both IMem read ports,
// fills the fetch queue and handles redirects. Optional perf counters: IMEM_FETCH_PERF_EN.
module imem_fetch_ctrl
   import imem_fetch_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int IMEM_AW    = IMEM_AW_DEF,
   parameter int FQ_DEPTH   = FQ_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_en,
   output logic [IMEM_AW-1:0]    imem_a1,
   output logic [IMEM_AW-1:0]    imem_a2,
   input  logic [DATA_WIDTH-1:0] imem_rd1,
   input  logic [DATA_WIDTH-1:0] imem_rd2,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [31:0]           inst_pc,
   output logic [31:0]           perf_stall_cnt,
   output logic [31:0]           perf_redir_cnt
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [1:0]    push_cnt;
   logic          pop;
   fq_entry_t     push0, push1, head;
   logic [CW-1:0] count, free;

   assign imem_a1    = fetch_pc_q[IMEM_AW+1:2];
   assign imem_a2    = imem_a1 + IMEM_AW'(1);
   assign inst_valid = (count != '0);
   assign inst       = head.inst;
   assign inst_pc    = head.pc;
   assign pop        = inst_valid && inst_ready && !redirect_valid;

   // Space is judged on the start-of-cycle count; a same-cycle pop does not help.
   always_comb begin
      push_cnt   = 2'd0;
      fetch_pc_d = fetch_pc_q;
      push0.pc   = fetch_pc_q;
      push0.inst = imem_rd1;
      push1.pc   = fetch_pc_q + 32'd4;
      push1.inst = imem_rd2;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      end else if (fetch_en) begin
         if (free >= CW'(2)) begin
            push_cnt   = 2'd2;
            fetch_pc_d = fetch_pc_q + 32'd8;
         end else if (free == CW'(1)) begin
            push_cnt   = 2'd1;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fetch_pc_q <= '0;
      else     fetch_pc_q <= fetch_pc_d;
   end

   imem_fetch_ctrl_fetch_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_fq (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (redirect_valid),
      .push_cnt_i (push_cnt),
      .push0_i    (push0),
      .push1_i    (push1),
      .pop_i      (pop),
      .head_o     (head),
      .count_o    (count),
      .free_o     (free)
   );

`ifdef IMEM_FETCH_PERF_EN
   logic [31:0] stall_cnt_q, redir_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         if (inst_valid && !inst_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (redirect_valid)            redir_cnt_q <= redir_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_redir_cnt = redir_cnt_q;
`else
   assign perf_stall_cnt = 32'd0;
   assign perf_redir_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the fetch rules.
module tb_imem_fetch_ctrl;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          fetch_en = 1'b0;
   logic          redirect_valid = 1'b0;
   logic          inst_ready = 1'b0;
   logic [31:0]   redirect_pc = 32'd0;
   logic [AW-1:0] imem_a1, imem_a2;
   logic [DW-1:0] imem_rd1, imem_rd2, inst;
   logic          inst_valid;
   logic [31:0]   inst_pc, perf_stall_cnt, perf_redir_cnt;

   logic [31:0]   mem [64];

   assign imem_rd1 = mem[imem_a1];
   assign imem_rd2 = mem[imem_a2];

   always #5 clk = ~clk;

   imem_fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .imem_a1        (imem_a1),
      .imem_a2        (imem_a2),
      .imem_rd1       (imem_rd1),
      .imem_rd2       (imem_rd2),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_redir_cnt (perf_redir_cnt)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] w;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mpc, m_inst, m_pc, m_stall, m_redir;
   int          n_cmp = 0;
   int          n_fail = 0;

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return mem[(pc >> 2) % 64];
   endfunction

   function automatic logic [31:0] exp_stall();
`ifdef IMEM_FETCH_PERF_EN
      return m_stall;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] exp_redir();
`ifdef IMEM_FETCH_PERF_EN
      return m_redir;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      mpc = 0; m_inst = 0; m_pc = 0; m_stall = 0; m_redir = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Drive one cycle of inputs (from a negedge), advance the model, land on the next negedge.
   task automatic cycle(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
      int free;
      fetch_en = en; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      free = D - mq.size();
      if (mq.size() != 0 && !rdy) m_stall++;
      if (rv) begin
         m_redir++;
         mq.delete();
         mpc = {rpc[31:2], 2'b00};
      end else begin
         if (mq.size() != 0 && rdy) void'(mq.pop_front());
         if (en && free >= 1) begin mq.push_back('{pc: mpc,       w: word_at(mpc)});       end
         if (en && free >= 2) begin mq.push_back('{pc: mpc + 4,   w: word_at(mpc + 4)});   end
         if (en && free >= 2) mpc += 8;
         else if (en && free == 1) mpc += 4;
      end
      if (mq.size() != 0) begin m_inst = mq[0].w; m_pc = mq[0].pc; end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
      n_cmp++; if (inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst); end
      n_cmp++; if (inst_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", inst_pc); end
      n_cmp++; if (imem_a1 !== 6'd0 || imem_a2 !== 6'd1) begin n_fail++; $display("FAIL reset_addr got %0d/%0d want 0/1", imem_a1, imem_a2); end
      n_cmp++; if (perf_stall_cnt !== 32'd0 || perf_redir_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_stall_cnt, perf_redir_cnt); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_stream();
      do_reset();
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_pre_valid got %0b want 0", inst_valid); end
      cycle(1, 1, 0, 0);
      n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h34080005 || inst_pc !== 32'd0) begin
         n_fail++; $display("FAIL stream_first got v=%0b %h/%h want 1 34080005/0", inst_valid, inst, inst_pc); end
      cycle(1, 1, 0, 0);
      n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h3409000A || inst_pc !== 32'd4) begin
         n_fail++; $display("FAIL stream_second got v=%0b %h/%h want 1 3409000A/4", inst_valid, inst, inst_pc); end
      for (int k = 2; k < 10; k++) begin
         cycle(1, 1, 0, 0);
         n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst !== mem[k]) begin
            n_fail++; $display("FAIL stream_k%0d got v=%0b %h/%h want 1 %h/%h", k, inst_valid, inst, inst_pc, mem[k], 4 * k); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] want_st;
      do_reset();
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
`ifdef IMEM_FETCH_PERF_EN
      want_st = 32'd10;
`else
      want_st = 32'd0;
`endif
      n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h34080005 || inst_pc !== 32'd0) begin
         n_fail++; $display("FAIL stall_head got v=%0b %h/%h want 1 34080005/0", inst_valid, inst, inst_pc); end
      n_cmp++; if (imem_a1 !== 6'd4) begin n_fail++; $display("FAIL stall_pc_hold got a1=%0d want 4", imem_a1); end
      n_cmp++; if (perf_stall_cnt !== want_st) begin n_fail++; $display("FAIL stall_perf got %0d want %0d", perf_stall_cnt, want_st); end
      for (int k = 1; k < 4; k++) begin
         cycle(0, 1, 0, 0);
         n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst !== mem[k]) begin
            n_fail++; $display("FAIL stall_drain_k%0d got v=%0b %h/%h want 1 %h/%h", k, inst_valid, inst, inst_pc, mem[k], 4 * k); end
      end
      cycle(0, 1, 0, 0);
      n_cmp++; if (inst_valid !== 1'b0 || inst_pc !== 32'd12 || inst !== mem[3]) begin
         n_fail++; $display("FAIL stall_empty_hold got v=%0b %h/%h want 0 %h/c", inst_valid, inst, inst_pc, mem[3]); end
   endtask

   task automatic test_partial();
      do_reset();
      cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      n_cmp++; if (imem_a1 !== 6'd4 || inst_pc !== 32'd4) begin n_fail++; $display("FAIL partial_three got a1=%0d pc=%h want 4/4", imem_a1, inst_pc); end
      cycle(1, 0, 0, 0);
      n_cmp++; if (imem_a1 !== 6'd5 || imem_a2 !== 6'd6) begin n_fail++; $display("FAIL partial_one_push got %0d/%0d want 5/6", imem_a1, imem_a2); end
      cycle(1, 0, 0, 0);
      n_cmp++; if (imem_a1 !== 6'd5) begin n_fail++; $display("FAIL partial_full_hold got a1=%0d want 5", imem_a1); end
      for (int k = 2; k < 5; k++) begin
         cycle(0, 1, 0, 0);
         n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst !== mem[k]) begin
            n_fail++; $display("FAIL partial_drain_k%0d got v=%0b %h/%h want 1 %h/%h", k, inst_valid, inst, inst_pc, mem[k], 4 * k); end
      end
      cycle(0, 1, 0, 0);
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL partial_empty got %0b want 0", inst_valid); end
   endtask

   task automatic test_redirect();
      do_reset();
      cycle(1, 1, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 32'h23);
      n_cmp++; if (inst_valid !== 1'b0 || imem_a1 !== 6'd8 || inst_pc !== 32'd4) begin
         n_fail++; $display("FAIL redir_gap got v=%0b a1=%0d pc=%h want 0/8/4", inst_valid, imem_a1, inst_pc); end
      cycle(1, 1, 0, 0);
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst !== mem[8]) begin
         n_fail++; $display("FAIL redir_target got v=%0b %h/%h want 1 %h/20", inst_valid, inst, inst_pc, mem[8]); end
      cycle(1, 1, 1, 32'h40);
      cycle(1, 1, 1, 32'h86);
      n_cmp++; if (inst_valid !== 1'b0 || imem_a1 !== 6'd33) begin
         n_fail++; $display("FAIL redir_b2b_gap got v=%0b a1=%0d want 0/33", inst_valid, imem_a1); end
      cycle(1, 1, 0, 0);
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h84 || inst !== mem[33]) begin
         n_fail++; $display("FAIL redir_b2b_target got v=%0b %h/%h want 1 %h/84", inst_valid, inst, inst_pc, mem[33]); end
   endtask

   task automatic test_wrap();
      do_reset();
      cycle(0, 0, 1, 32'hF8);
      n_cmp++; if (imem_a1 !== 6'd62 || imem_a2 !== 6'd63) begin n_fail++; $display("FAIL wrap_f8 got %0d/%0d want 62/63", imem_a1, imem_a2); end
      cycle(1, 0, 0, 0);
      n_cmp++; if (imem_a1 !== 6'd0 || imem_a2 !== 6'd1 || inst_pc !== 32'hF8 || inst !== mem[62]) begin
         n_fail++; $display("FAIL wrap_next got %0d/%0d %h/%h want 0/1 %h/f8", imem_a1, imem_a2, inst, inst_pc, mem[62]); end
      cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);
      n_cmp++; if (inst_pc !== 32'h100 || inst !== mem[0]) begin n_fail++; $display("FAIL wrap_100 got %h/%h want %h/100", inst, inst_pc, mem[0]); end
      cycle(0, 1, 0, 0);
      n_cmp++; if (inst_pc !== 32'h104 || inst !== mem[1]) begin n_fail++; $display("FAIL wrap_104 got %h/%h want %h/104", inst, inst_pc, mem[1]); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      cycle(1, 1, 1, 32'h10);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10) begin n_fail++; $display("FAIL midrst_pre got v=%0b pc=%h want 1/10", inst_valid, inst_pc); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0 || imem_a1 !== 6'd0) begin
         n_fail++; $display("FAIL midrst_outputs got v=%0b %h/%h a1=%0d want 0 0/0 0", inst_valid, inst, inst_pc, imem_a1); end
      n_cmp++; if (perf_stall_cnt !== 32'd0 || perf_redir_cnt !== 32'd0) begin
         n_fail++; $display("FAIL midrst_perf got %0d/%0d want 0/0", perf_stall_cnt, perf_redir_cnt); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cycle(1, 1, 0, 0);
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst !== mem[0]) begin
         n_fail++; $display("FAIL midrst_restart got v=%0b %h/%h want 1 %h/0", inst_valid, inst, inst_pc, mem[0]); end
   endtask

   task automatic test_random();
      logic en, rdy, rv;
      logic [31:0] rpc;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         n_cmp++; if (inst_valid !== (mq.size() != 0) || inst !== m_inst || inst_pc !== m_pc) begin
            n_fail++; $display("FAIL rand_out_%0d got v=%0b %h/%h want %0b %h/%h", i, inst_valid, inst, inst_pc, mq.size() != 0, m_inst, m_pc); end
         n_cmp++; if (imem_a1 !== AW'((mpc >> 2) % 64) || imem_a2 !== AW'(((mpc >> 2) + 1) % 64)) begin
            n_fail++; $display("FAIL rand_addr_%0d got %0d/%0d want %0d/%0d", i, imem_a1, imem_a2, (mpc >> 2) % 64, ((mpc >> 2) + 1) % 64); end
         n_cmp++; if (perf_stall_cnt !== exp_stall() || perf_redir_cnt !== exp_redir()) begin
            n_fail++; $display("FAIL rand_perf_%0d got %0d/%0d want %0d/%0d", i, perf_stall_cnt, perf_redir_cnt, exp_stall(), exp_redir()); end
         en  = ($urandom_range(0, 9) < 8);
         rdy = ($urandom_range(0, 9) < 5);
         rv  = ($urandom_range(0, 19) == 0);
         rpc = $urandom;
         cycle(en, rdy, rv, rpc);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h34080005;
      mem[1] = 32'h3409000A;
      model_reset();
      test_reset();
      test_stream();
      test_stall();
      test_partial();
      test_redirect();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
